// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 16x oversampled UART receive stage with parity and framing checks
module uart_receiver #(
    parameter int CLK_FREQ   = 50000000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       data_rx,
    input  logic [1:0] parity_type,
    input  logic [1:0] baud_rate,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       parity_error,
    output logic       stop_error,
    output logic       active_flag,
    output logic       done_flag
);

    localparam int DIV0 = (CLK_FREQ + 8 * 2400)  / (OVERSAMPLE * 2400);
    localparam int DIV1 = (CLK_FREQ + 8 * 4800)  / (OVERSAMPLE * 4800);
    localparam int DIV2 = (CLK_FREQ + 8 * 9600)  / (OVERSAMPLE * 9600);
    localparam int DIV3 = (CLK_FREQ + 8 * 19200) / (OVERSAMPLE * 19200);
    localparam int CW   = $clog2(DIV0 + 1);

    localparam logic [3:0] SAMP_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] SAMP_LAST = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state_q;
    logic          rx_meta_q;
    logic          rxs_q;
    logic          rxs_prev_q;
    logic [CW-1:0] tick_cnt_q;
    logic [3:0]    samp_cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic [1:0]    baud_q;
    logic [1:0]    parity_q;
    logic          par_err_q;
    logic          stop_bit_q;
    logic          deliver_q;
    logic [7:0]    data_out_q;
    logic          rx_valid_q;
    logic          parity_error_q;
    logic          stop_error_q;
    logic          active_q;
    logic          done_q;

    logic [CW-1:0] div_m1;
    logic          tick;
    logic          start_edge;
    logic          par_en;

    always_comb begin
        div_m1 = CW'(DIV0 - 1);
        case (baud_q)
            2'b00:   div_m1 = CW'(DIV0 - 1);
            2'b01:   div_m1 = CW'(DIV1 - 1);
            2'b10:   div_m1 = CW'(DIV2 - 1);
            default: div_m1 = CW'(DIV3 - 1);
        endcase
    end

    assign tick       = (tick_cnt_q == div_m1);
    assign start_edge = rxs_prev_q & ~rxs_q;
    assign par_en     = parity_q[0] ^ parity_q[1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            rx_meta_q      <= 1'b1;
            rxs_q          <= 1'b1;
            rxs_prev_q     <= 1'b1;
            tick_cnt_q     <= '0;
            samp_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            baud_q         <= '0;
            parity_q       <= '0;
            par_err_q      <= 1'b0;
            stop_bit_q     <= 1'b0;
            deliver_q      <= 1'b0;
            data_out_q     <= '0;
            rx_valid_q     <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
            active_q       <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            rx_meta_q  <= data_rx;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
            rx_valid_q <= 1'b0;

            // Realigning the tick phase at the start edge keeps every later sample mid-bit.
            if ((state_q == IDLE && start_edge) || tick) begin
                tick_cnt_q <= '0;
            end else begin
                tick_cnt_q <= tick_cnt_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        baud_q     <= baud_rate;
                        parity_q   <= parity_type;
                        samp_cnt_q <= '0;
                        active_q   <= 1'b1;
                        done_q     <= 1'b0;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (samp_cnt_q == SAMP_MID) begin
                            samp_cnt_q <= '0;
                            bit_cnt_q  <= '0;
                            if (rxs_q) begin
                                active_q <= 1'b0;
                                state_q  <= IDLE;
                            end else begin
                                state_q <= DATA;
                            end
                        end else begin
                            samp_cnt_q <= samp_cnt_q + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (samp_cnt_q == SAMP_LAST) begin
                            samp_cnt_q <= '0;
                            shift_q    <= {rxs_q, shift_q[7:1]};
                            bit_cnt_q  <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= par_en ? PARITY : STOP;
                            end
                        end else begin
                            samp_cnt_q <= samp_cnt_q + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        if (samp_cnt_q == SAMP_LAST) begin
                            samp_cnt_q <= '0;
                            par_err_q  <= (parity_q == 2'b01) ? ~(^shift_q ^ rxs_q)
                                                              :  (^shift_q ^ rxs_q);
                            state_q    <= STOP;
                        end else begin
                            samp_cnt_q <= samp_cnt_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (deliver_q) begin
                        deliver_q      <= 1'b0;
                        data_out_q     <= shift_q;
                        rx_valid_q     <= 1'b1;
                        parity_error_q <= par_en & par_err_q;
                        stop_error_q   <= ~stop_bit_q;
                        active_q       <= 1'b0;
                        done_q         <= 1'b1;
                        state_q        <= stop_bit_q ? IDLE : WAIT_HIGH;
                    end else if (tick) begin
                        if (samp_cnt_q == SAMP_LAST) begin
                            samp_cnt_q <= '0;
                            stop_bit_q <= rxs_q;
                            deliver_q  <= 1'b1;
                        end else begin
                            samp_cnt_q <= samp_cnt_q + 1'b1;
                        end
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line (break) must not look like a fresh start bit.
                    if (rxs_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out     = data_out_q;
    assign rx_valid     = rx_valid_q;
    assign parity_error = parity_error_q;
    assign stop_error   = stop_error_q;
    assign active_flag  = active_q;
    assign done_flag    = done_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver
module tb_uart_receiver;

    // CLK_FREQ = 1 MHz gives DIV = 26 / 13 / 7 / 3, so bit times of 416 / 208 / 112 / 48 clocks.
    localparam int BT0 = 416;
    localparam int BT3 = 48;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       data_rx;
    logic [1:0] parity_type;
    logic [1:0] baud_rate;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       parity_error;
    logic       stop_error;
    logic       active_flag;
    logic       done_flag;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         vcnt     = 0;
    int         vcyc     = 0;
    int         t_start  = 0;
    int         lat;
    int         vbase;
    bit         active_seen = 1'b0;
    logic [7:0] rx_bytes[$];

    uart_receiver #(.CLK_FREQ(1000000), .OVERSAMPLE(16)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .data_rx      (data_rx),
        .parity_type  (parity_type),
        .baud_rate    (baud_rate),
        .data_out     (data_out),
        .rx_valid     (rx_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .active_flag  (active_flag),
        .done_flag    (done_flag)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (rx_valid) begin
            vcnt = vcnt + 1;
            vcyc = cyc;
            rx_bytes.push_back(data_out);
        end
        if (active_flag) active_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        data_rx = v;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit pen, input bit pbit,
                              input bit sbit, input int bt);
        data_rx = 1'b0;
        t_start = cyc;
        repeat (bt) @(negedge clock);
        for (int i = 0; i < 8; i++) hold(b[i], bt);
        if (pen) hold(pbit, bt);
        hold(sbit, bt);
    endtask

    initial begin
        reset_n     = 1'b0;
        data_rx     = 1'b1;
        parity_type = 2'b00;
        baud_rate   = 2'b11;
        repeat (4) @(negedge clock);
        check("reset_outputs", {data_out, rx_valid, parity_error, stop_error, active_flag, done_flag}, 32'h0);
        reset_n = 1'b1;
        hold(1'b1, 2 * BT3);

        // 0xA5, no parity, 19200 code
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, BT3);
        lat = vcyc - t_start;
        check("t1_count", vcnt, 1);
        check("t1_data", data_out, 8'hA5);
        check("t1_perr", parity_error, 0);
        check("t1_serr", stop_error, 0);
        check("t1_done", done_flag, 1);
        check("t1_active", active_flag, 0);
        check("t1_latency_window", (lat >= 456 && lat <= 464), 1);
        hold(1'b1, BT3);

        // odd parity: 0x3C has even weight, so parity bit 1 is correct and 0 is wrong
        parity_type = 2'b01;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, BT3);
        check("t2a_count", vcnt, 2);
        check("t2a_perr", parity_error, 0);
        hold(1'b1, BT3);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, BT3);
        check("t2b_count", vcnt, 3);
        check("t2b_perr", parity_error, 1);
        check("t2b_data", data_out, 8'h3C);
        hold(1'b1, BT3);

        // even parity, framing error followed by a held-low line
        parity_type = 2'b10;
        send_frame(8'h00, 1'b1, 1'b0, 1'b0, BT3);
        check("t3_count", vcnt, 4);
        check("t3_serr", stop_error, 1);
        check("t3_perr", parity_error, 0);
        check("t3_data", data_out, 8'h00);
        active_seen = 1'b0;
        hold(1'b0, 3 * BT3);
        check("t3_no_retrigger", active_seen, 0);
        hold(1'b1, 2 * BT3);
        check("t3_count_after", vcnt, 4);
        check("t3_active_after", active_seen, 0);

        // quarter-bit glitch: false start
        active_seen = 1'b0;
        hold(1'b0, BT3 / 4);
        hold(1'b1, 2 * BT3);
        check("t4_active_pulse", active_seen, 1);
        check("t4_active_clear", active_flag, 0);
        check("t4_count", vcnt, 4);
        check("t4_serr_kept", stop_error, 1);
        check("t4_perr_kept", parity_error, 0);
        check("t4_done", done_flag, 0);

        // back-to-back frames at 2400 code
        baud_rate   = 2'b00;
        parity_type = 2'b00;
        rx_bytes.delete();
        send_frame(8'h12, 1'b0, 1'b0, 1'b1, BT0);
        send_frame(8'hFE, 1'b0, 1'b0, 1'b1, BT0);
        hold(1'b1, BT0);
        check("t5_count", vcnt, 6);
        check("t5_nbytes", rx_bytes.size(), 2);
        if (rx_bytes.size() == 2) begin
            check("t5_first", rx_bytes[0], 8'h12);
            check("t5_second", rx_bytes[1], 8'hFE);
        end
        check("t5_serr", stop_error, 0);

        // reset mid-DATA, then a clean frame
        baud_rate = 2'b11;
        vbase     = vcnt;
        hold(1'b0, BT3);
        hold(1'b1, BT3);
        hold(1'b0, BT3);
        hold(1'b1, BT3);
        hold(1'b0, BT3 / 2);
        check("t6_active_mid", active_flag, 1);
        reset_n = 1'b0;
        #1;
        check("t6_reset_outputs", {data_out, rx_valid, parity_error, stop_error, active_flag, done_flag}, 32'h0);
        data_rx = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        hold(1'b1, 2 * BT3);
        check("t6_no_pulse", vcnt, vbase);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, BT3);
        hold(1'b1, BT3);
        check("t6_count", vcnt, vbase + 1);
        check("t6_data", data_out, 8'h81);
        check("t6_errs", {parity_error, stop_error}, 0);
        check("t6_done", done_flag, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
